fixed_point_moving_average: RTL and testbench

Streaming boxcar (moving-average) filter that sits directly downstream of the fixed-point adder and consumes its 8-bit signed Q1.7 sum stream. It keeps the last 2^LOG2_TAPS accepted samples in a circular buffer and maintains a running sum. For each accepted sample it emits the rounded mean through one registered output stage with a valid/ready handshake.

---
 rtl/fixed_point_pkg.sv | 17 +
 rtl/fixed_point_sample_ring.sv | 51 +++++
 rtl/fixed_point_moving_average.sv | 106 ++++++++++
 tb/tb_fixed_point_moving_average.sv | 237 +++++++++++++++++++++++
 4 files changed

// File: rtl/fixed_point_pkg.sv
// Shared types and helpers for the fixed-point datapath blocks.
// Samples are signed two's complement Q1.7.
package fixed_point_pkg;

    localparam int DATA_W = 8;

    typedef logic signed [DATA_W-1:0] sample_t;

    // Add half an LSB of the result, then shift arithmetically: rounds half toward +inf.
    function automatic logic signed [31:0] round_shift(input logic signed [31:0] sum,
                                                      input int unsigned       shift);
        logic signed [31:0] half;
        half = 32'sd1 <<< (shift - 1);
        return (sum + half) >>> shift;
    endfunction

endpackage

// File: rtl/fixed_point_sample_ring.sv
// TAPS-deep circular sample buffer; presents the oldest sample, which is the
// entry at the write pointer and is about to be overwritten.
module fixed_point_sample_ring #(
    parameter int DATA_W    = 8,
    parameter int LOG2_TAPS = 2
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     clear,
    input  logic                     wr_en,
    input  logic signed [DATA_W-1:0] wr_data,
    output logic signed [DATA_W-1:0] oldest
);
    import fixed_point_pkg::*;

    localparam int unsigned TAPS = 1 << LOG2_TAPS;

    logic signed [DATA_W-1:0] ring_q [TAPS];
    logic signed [DATA_W-1:0] ring_d [TAPS];
    logic [LOG2_TAPS-1:0]     wr_ptr_q;
    logic [LOG2_TAPS-1:0]     wr_ptr_d;

    always_comb begin
        ring_d   = ring_q;
        wr_ptr_d = wr_ptr_q;
        if (clear) begin
            for (int unsigned i = 0; i < TAPS; i++) begin
                ring_d[i] = '0;
            end
            wr_ptr_d = '0;
        end else if (wr_en) begin
            ring_d[wr_ptr_q] = wr_data;
            wr_ptr_d         = wr_ptr_q + LOG2_TAPS'(1);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int unsigned i = 0; i < TAPS; i++) begin
                ring_q[i] <= '0;
            end
            wr_ptr_q <= '0;
        end else begin
            ring_q   <= ring_d;
            wr_ptr_q <= wr_ptr_d;
        end
    end

    assign oldest = ring_q[wr_ptr_q];

endmodule

// File: rtl/fixed_point_moving_average.sv
// Streaming boxcar filter: running sum over the last TAPS samples, emits the
// rounded mean through a single registered valid/ready output stage.
module fixed_point_moving_average #(
    parameter int DATA_W    = 8,
    parameter int LOG2_TAPS = 2
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     flush,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic signed [DATA_W-1:0] data_in,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic signed [DATA_W-1:0] data_out,
    output logic                     primed
);
    import fixed_point_pkg::*;

    localparam int             SUM_W    = DATA_W + LOG2_TAPS;
    localparam int unsigned    TAPS     = 1 << LOG2_TAPS;
    localparam logic [LOG2_TAPS:0] TAPS_CNT = (LOG2_TAPS + 1)'(TAPS);

    typedef enum logic {FILL, RUN} state_t;

    state_t                   state_q, state_d;
    logic [LOG2_TAPS:0]       fill_cnt_q, fill_cnt_d;
    logic signed [SUM_W-1:0]  sum_q, sum_d, sum_n;
    logic                     out_valid_q, out_valid_d;
    logic signed [DATA_W-1:0] data_out_q, data_out_d;
    logic                     primed_q, primed_d;
    logic                     accept;
    logic signed [DATA_W-1:0] oldest;

    fixed_point_sample_ring #(
        .DATA_W    (DATA_W),
        .LOG2_TAPS (LOG2_TAPS)
    ) u_ring (
        .clk     (clk),
        .reset   (reset),
        .clear   (flush),
        .wr_en   (accept),
        .wr_data (data_in),
        .oldest  (oldest)
    );

    always_comb begin
        in_ready    = !flush && (!out_valid_q || out_ready);
        accept      = in_valid && in_ready;
        sum_n       = sum_q + SUM_W'(data_in) - SUM_W'(oldest);

        state_d     = state_q;
        fill_cnt_d  = fill_cnt_q;
        sum_d       = sum_q;
        primed_d    = primed_q;
        out_valid_d = out_valid_q;
        data_out_d  = data_out_q;

        if (flush) begin
            state_d    = FILL;
            fill_cnt_d = '0;
            sum_d      = '0;
            primed_d   = 1'b0;
        end else if (accept) begin
            sum_d = sum_n;
            if (state_q == FILL) begin
                fill_cnt_d = fill_cnt_q + (LOG2_TAPS + 1)'(1);
                if (fill_cnt_d == TAPS_CNT) begin
                    state_d  = RUN;
                    primed_d = 1'b1;
                end
            end
        end

        // A pending result survives a flush; only a handshake retires it.
        if (accept) begin
            out_valid_d = 1'b1;
            data_out_d  = DATA_W'(round_shift(32'(sum_n), LOG2_TAPS));
        end else if (out_ready) begin
            out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= FILL;
            fill_cnt_q  <= '0;
            sum_q       <= '0;
            primed_q    <= 1'b0;
            out_valid_q <= 1'b0;
            data_out_q  <= '0;
        end else begin
            state_q     <= state_d;
            fill_cnt_q  <= fill_cnt_d;
            sum_q       <= sum_d;
            primed_q    <= primed_d;
            out_valid_q <= out_valid_d;
            data_out_q  <= data_out_d;
        end
    end

    assign out_valid = out_valid_q;
    assign data_out  = data_out_q;
    assign primed    = primed_q;

endmodule

// File: tb/tb_fixed_point_moving_average.sv
// Scoreboard bench for the moving-average filter: stimulus pushes hand-computed
// expectations, a monitor pops them on every output handshake.
module tb_fixed_point_moving_average;

    logic              clk = 1'b0;
    logic              reset;
    logic              flush;
    logic              in_valid;
    logic              in_ready;
    logic signed [7:0] data_in;
    logic              out_valid;
    logic              out_ready;
    logic signed [7:0] data_out;
    logic              primed;

    typedef struct packed {
        logic              primed;
        logic signed [7:0] data;
    } exp_t;

    exp_t exp_q[$];
    int   vectors     = 0;
    int   miscompares = 0;

    fixed_point_moving_average #(
        .DATA_W    (8),
        .LOG2_TAPS (2)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .data_in   (data_in),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .data_out  (data_out),
        .primed    (primed)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int req);
        vectors++;
        if (act != req) begin
            miscompares++;
            $display("FAIL %s: got %0d, expected %0d", name, act, req);
        end
    endtask

    task automatic send(input int x, input int exp_d, input bit exp_p);
        int n = 0;
        @(negedge clk);
        in_valid = 1'b1;
        data_in  = 8'(x);
        #1;
        while (!in_ready && n < 50) begin
            @(negedge clk);
            #1;
            n++;
        end
        if (!in_ready) check("accept_timeout", 0, 1);
        else exp_q.push_back('{primed: exp_p, data: 8'(exp_d)});
        @(posedge clk);
    endtask

    task automatic idle();
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        while (exp_q.size() != 0 && n < 50) begin
            @(posedge clk);
            n++;
        end
        check("drain_pending", exp_q.size(), 0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset     = 1'b1;
        in_valid  = 1'b0;
        flush     = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        reset = 1'b0;
    endtask

    // Monitor samples just before each rising edge, after all stimulus has settled.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            #4;
            if (!reset && out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    vectors++;
                    miscompares++;
                    $display("FAIL unexpected_output: got %0d, expected none", data_out);
                end else begin
                    e = exp_q.pop_front();
                    check("data_out", int'(data_out), int'(e.data));
                    check("primed", int'(primed), int'(e.primed));
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1);
    end

    initial begin
        reset     = 1'b1;
        flush     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        data_in   = '0;
        #12;
        check("reset_out_valid", int'(out_valid), 0);
        check("reset_data_out", int'(data_out), 0);
        check("reset_primed", int'(primed), 0);
        check("reset_in_ready", int'(in_ready), 1);
        @(negedge clk);
        reset = 1'b0;

        // Step response
        send(64, 16, 1'b0);
        send(64, 32, 1'b0);
        send(64, 48, 1'b0);
        send(64, 64, 1'b1);
        send(64, 64, 1'b1);
        idle();
        drain();

        // Rounding
        do_reset();
        send(1, 0, 1'b0);
        send(1, 1, 1'b0);
        idle();
        drain();
        do_reset();
        send(-1, 0, 1'b0);
        idle();
        drain();

        // Negative extreme
        do_reset();
        send(-128, -32, 1'b0);
        send(-128, -64, 1'b0);
        send(-128, -96, 1'b0);
        send(-128, -128, 1'b1);
        send(-128, -128, 1'b1);
        idle();
        drain();

        // Backpressure
        do_reset();
        @(negedge clk);
        out_ready = 1'b0;
        send(10, 3, 1'b0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            data_in = 8'sd20;
            #1;
            check("stall_in_ready", int'(in_ready), 0);
            check("stall_out_valid", int'(out_valid), 1);
            check("stall_data_out", int'(data_out), 3);
        end
        out_ready = 1'b1;
        #1;
        check("release_in_ready", int'(in_ready), 1);
        exp_q.push_back('{primed: 1'b0, data: 8'sd8});
        @(posedge clk);
        send(30, 15, 1'b0);
        send(40, 25, 1'b1);

        // Window of 10,20,30,40 replaced by 64s
        send(64, 39, 1'b1);
        send(64, 50, 1'b1);
        send(64, 58, 1'b1);
        send(64, 64, 1'b1);

        // Flush with a coincident sample
        @(negedge clk);
        flush    = 1'b1;
        in_valid = 1'b1;
        data_in  = 8'sd64;
        #1;
        check("flush_in_ready", int'(in_ready), 0);
        @(posedge clk);
        @(negedge clk);
        flush    = 1'b0;
        in_valid = 1'b0;
        #1;
        check("flush_primed", int'(primed), 0);
        drain();
        send(64, 16, 1'b0);
        send(64, 32, 1'b0);
        send(64, 48, 1'b0);
        send(64, 64, 1'b1);
        idle();
        drain();

        // Asynchronous reset with a pending output
        @(negedge clk);
        out_ready = 1'b0;
        in_valid  = 1'b1;
        data_in   = 8'sd64;
        @(posedge clk);
        #1;
        check("pend_out_valid", int'(out_valid), 1);
        check("pend_data_out", int'(data_out), 64);
        check("pend_primed", int'(primed), 1);
        #1;
        reset = 1'b1;
        #1;
        check("areset_out_valid", int'(out_valid), 0);
        check("areset_data_out", int'(data_out), 0);
        check("areset_primed", int'(primed), 0);
        in_valid = 1'b0;
        @(negedge clk);
        reset     = 1'b0;
        out_ready = 1'b1;
        send(64, 16, 1'b0);
        idle();
        drain();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
